ifetch_sram_ctrl: RTL and testbench

// Instruction-fetch front end between the pipeline fetch stage and the SRAM-like instruction bus.

---
 rtl/ifetch_sram_ctrl.sv | 102 ++++++++++
 tb/tb_ifetch_sram_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_sram_ctrl.sv
// Instruction-fetch front end for an SRAM-like instruction bus.
// Keeps at most one request outstanding, holds the returned word for the
// decode register, and discards responses that belong to redirected fetches.
module ifetch_sram_ctrl #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0,
    parameter int              CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              stall_o,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        CANCEL = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              misaligned;

    assign misaligned = (pc_i[1:0] != 2'b00);

    // Next-state, buffer update and bus request decode
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        inst_req = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (misaligned) begin
                    // No bus access; the pipeline raises AdEL from pc[1:0].
                    buf_d   = NOP_INSTR;
                    state_d = DONE;
                end else begin
                    inst_req = 1'b1;
                    // Without addr_ok the address simply follows the new pc_i.
                    if (inst_addr_ok) state_d = flush_i ? CANCEL : WAIT;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (flush_i) begin
                        state_d = REQ;
                    end else begin
                        buf_d   = inst_rdata;
                        state_d = DONE;
                    end
                end else if (flush_i) begin
                    state_d = CANCEL;
                end
            end
            // Drain the response of the cancelled fetch before issuing again.
            CANCEL: if (inst_data_ok) state_d = REQ;
            DONE:   if (flush_i || !stall_i) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // Stall counter: counts every cycle the decode stage is held by fetch
    always_comb begin
        cnt_d = cnt_q;
        if (stall_o) cnt_d = cnt_q + 1'b1;
    end

    // State, instruction buffer and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= NOP_INSTR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered-state decode only: no bus input reaches stall_o.
    assign stall_o   = (state_q != DONE);
    assign instr_o   = buf_q;
    assign inst_addr = pc_i;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ifetch_sram_ctrl.sv
// Bench for ifetch_sram_ctrl: cycle vectors with expected outputs go through
// a scoreboard queue, plus a hand-written mid-transaction reset sequence.
module tb_ifetch_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        stall_i, flush_i;
    logic [31:0] instr_o;
    logic        stall_o, inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cnt;
    bit seen_deadbeef = 0;

    always #5 clk = ~clk;

    ifetch_sram_ctrl #(
        .ADDR_W(32), .DATA_W(32), .NOP_INSTR(32'h0), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
        .instr_o(instr_o), .stall_o(stall_o), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        stl, fl, aok, dok;
        logic [31:0] rdata;
        logic        ereq, estall;
        logic [31:0] einstr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(logic [31:0] pc, logic stl, logic fl, logic aok, logic dok,
                                logic [31:0] rdata, logic ereq, logic estall,
                                logic [31:0] einstr);
        vec_t v;
        v.pc = pc; v.stl = stl; v.fl = fl; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.ereq = ereq; v.estall = estall; v.einstr = einstr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (instr_o === 32'hDEADBEEF) seen_deadbeef = 1;

    initial begin
        //              pc            stl fl aok dok rdata         req st instr
        // zero-wait fetch
        vecs.push_back(mk(32'hBFC00000, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0));        // IDLE
        vecs.push_back(mk(32'hBFC00000, 0, 0, 1, 0, 32'h0,        1, 1, 32'h0));        // REQ
        vecs.push_back(mk(32'hBFC00000, 0, 0, 0, 1, 32'h24080001, 0, 1, 32'h0));        // WAIT
        vecs.push_back(mk(32'hBFC00000, 0, 0, 0, 0, 32'h0,        0, 0, 32'h24080001)); // DONE
        // slow slave, stall_i held two cycles in DONE
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 0, 32'h0,        1, 1, 32'h24080001));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 0, 32'h0,        1, 1, 32'h24080001));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 1, 0, 32'h0,        1, 1, 32'h24080001));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 0, 32'h0,        0, 1, 32'h24080001));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 0, 32'h0,        0, 1, 32'h24080001));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 0, 32'h0,        0, 1, 32'h24080001));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 1, 32'h8C090004, 0, 1, 32'h24080001));
        vecs.push_back(mk(32'hBFC00004, 1, 0, 0, 0, 32'h0,        0, 0, 32'h8C090004));
        vecs.push_back(mk(32'hBFC00004, 1, 0, 0, 0, 32'h0,        0, 0, 32'h8C090004));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 0, 32'h0,        0, 0, 32'h8C090004));
        // flush in WAIT without data, late response dropped
        vecs.push_back(mk(32'hBFC00008, 0, 0, 1, 0, 32'h0,        1, 1, 32'h8C090004));
        vecs.push_back(mk(32'hBFC00008, 0, 1, 0, 0, 32'h0,        0, 1, 32'h8C090004));
        vecs.push_back(mk(32'hBFC00380, 0, 0, 0, 0, 32'h0,        0, 1, 32'h8C090004)); // CANCEL
        vecs.push_back(mk(32'hBFC00380, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1, 32'h8C090004)); // dropped
        vecs.push_back(mk(32'hBFC00380, 0, 0, 1, 0, 32'h0,        1, 1, 32'h8C090004)); // REQ
        vecs.push_back(mk(32'hBFC00380, 0, 0, 0, 1, 32'h40806000, 0, 1, 32'h8C090004));
        vecs.push_back(mk(32'hBFC00380, 0, 0, 0, 0, 32'h0,        0, 0, 32'h40806000));
        // flush with simultaneous data_ok in WAIT
        vecs.push_back(mk(32'hBFC00384, 0, 0, 1, 0, 32'h0,        1, 1, 32'h40806000));
        vecs.push_back(mk(32'hBFC00384, 0, 1, 0, 1, 32'h11111111, 0, 1, 32'h40806000));
        vecs.push_back(mk(32'hBFC00100, 0, 0, 1, 0, 32'h0,        1, 1, 32'h40806000));
        vecs.push_back(mk(32'hBFC00100, 0, 0, 0, 1, 32'h22222222, 0, 1, 32'h40806000));
        // flush in DONE overrides stall_i; flush in REQ with and without addr_ok
        vecs.push_back(mk(32'hBFC00100, 1, 1, 0, 0, 32'h0,        0, 0, 32'h22222222));
        vecs.push_back(mk(32'hBFC00200, 0, 1, 0, 0, 32'h0,        1, 1, 32'h22222222));
        vecs.push_back(mk(32'hBFC00300, 0, 1, 1, 0, 32'h0,        1, 1, 32'h22222222));
        vecs.push_back(mk(32'hBFC00300, 0, 1, 0, 0, 32'h0,        0, 1, 32'h22222222)); // CANCEL
        vecs.push_back(mk(32'hBFC00300, 0, 0, 0, 1, 32'h33333333, 0, 1, 32'h22222222));
        // misaligned PC
        vecs.push_back(mk(32'hBFC00002, 0, 0, 1, 0, 32'h0,        0, 1, 32'h22222222));
        vecs.push_back(mk(32'hBFC00002, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0));
        // stray data_ok in REQ and in DONE is ignored
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 1, 32'h55555555, 1, 1, 32'h0));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 1, 0, 32'h0,        1, 1, 32'h0));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 1, 32'h66666666, 0, 1, 32'h0));
        vecs.push_back(mk(32'hBFC00004, 1, 0, 0, 1, 32'h77777777, 0, 0, 32'h66666666));
        vecs.push_back(mk(32'hBFC00004, 0, 0, 0, 0, 32'h0,        0, 0, 32'h66666666));
        vecs.push_back(mk(32'hBFC00008, 0, 0, 0, 0, 32'h0,        1, 1, 32'h66666666));

        // reset held two cycles
        rst = 1; pc_i = 32'hBFC00000; stall_i = 0; flush_i = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   {31'b0, inst_req}, 32'h0);
        chk("rst_stall", {31'b0, stall_o},  32'h1);
        chk("rst_cnt",   stall_cnt,         32'h0);
        chk("rst_instr", instr_o,           32'h0);
        rst = 0;
        exp_cnt = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v, e;
            v = vecs[i];
            pc_i = v.pc; stall_i = v.stl; flush_i = v.fl;
            inst_addr_ok = v.aok; inst_data_ok = v.dok; inst_rdata = v.rdata;
            sb.push_back(v);
            #1;
            e = sb.pop_front();
            chk($sformatf("req[%0d]", i),   {31'b0, inst_req}, {31'b0, e.ereq});
            chk($sformatf("stall[%0d]", i), {31'b0, stall_o},  {31'b0, e.estall});
            chk($sformatf("instr[%0d]", i), instr_o,           e.einstr);
            chk($sformatf("cnt[%0d]", i),   stall_cnt,         exp_cnt);
            if (e.ereq) chk($sformatf("addr[%0d]", i), inst_addr, e.pc);
            if (e.estall) exp_cnt = exp_cnt + 1;
            @(negedge clk);
        end

        // reset while a response is outstanding (state is REQ here)
        pc_i = 32'hBFC00010; stall_i = 0; flush_i = 0;
        inst_addr_ok = 1; inst_data_ok = 0;
        @(negedge clk);
        inst_addr_ok = 0;
        #1;
        chk("mid_wait_req", {31'b0, inst_req}, 32'h0);
        chk("mid_wait_stall", {31'b0, stall_o}, 32'h1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_rst_req",   {31'b0, inst_req}, 32'h0);
        chk("mid_rst_stall", {31'b0, stall_o},  32'h1);
        chk("mid_rst_cnt",   stall_cnt,         32'h0);
        chk("mid_rst_instr", instr_o,           32'h0);
        // stale response arrives in IDLE and must be ignored
        inst_data_ok = 1; inst_rdata = 32'h99999999;
        @(negedge clk);
        inst_data_ok = 0;
        #1;
        chk("post_rst_req",  {31'b0, inst_req}, 32'h1);
        chk("post_rst_addr", inst_addr,         32'hBFC00010);
        chk("post_rst_cnt",  stall_cnt,         32'h1);
        chk("post_rst_instr", instr_o,          32'h0);

        chk("deadbeef_never_shown", {31'b0, seen_deadbeef}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
